// File: rtl/updown_counter_pkg.sv
// Shared constants for the up/down modulo counter and its prescaler.
//   MODE_WRAP / MODE_SAT : values for the counter's SATURATE parameter
//   PRESC_W              : width of the prescaler's cycle counter
package updown_counter_pkg;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;
    localparam int PRESC_W   = 16;

endpackage : updown_counter_pkg

// File: rtl/tick_div.sv
// Prescaler: emits a one-cycle tick on every PRESCALE-th enabled cycle.
// Counting restarts from zero on reset or whenever restart is high.
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset
//   en      : count enable; holds the divider when low
//   restart : synchronous restart (no tick on a restart cycle)
//   tick    : combinational, high in the cycle whose edge completes a period
module tick_div
    import updown_counter_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic restart,
    output logic tick
);

    if (PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_prescale
        $error("tick_div: PRESCALE must be in 1..65535");
    end

    localparam logic [PRESC_W-1:0] PRE_TC = PRESC_W'(PRESCALE - 1);

    logic [PRESC_W-1:0] pre_q;
    logic [PRESC_W-1:0] pre_d;
    logic               at_tc;

    assign at_tc = (pre_q == PRE_TC);
    assign tick  = en & ~restart & at_tc;

    always_comb begin
        pre_d = pre_q;
        if (restart) begin
            pre_d = '0;
        end else if (en) begin
            pre_d = at_tc ? '0 : pre_q + PRESC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

endmodule : tick_div

// File: rtl/updown_mod_counter.sv
// Up/down modulo counter with prescaler, wrap/saturate at the range
// limits, a one-cycle wrap pulse and a sticky overflow flag.
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   en       : count enable (prescaler and counter hold when low)
//   up_dn    : 1 = count up, 0 = count down
//   clear    : synchronous clear of counter and prescaler (highest priority)
//   load     : synchronous load of min(load_val, MODULO-1)
//   load_val : value to load
//   ovf_clr  : clears ovf (a same-edge overflow event wins)
//   cnt      : registered count
//   wrap     : registered one-cycle pulse on a step at a range limit
//   ovf      : registered sticky overflow flag
module updown_mod_counter
    import updown_counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MODULO   = 16,
    parameter int SATURATE = 0,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] cnt,
    output logic             wrap,
    output logic             ovf
);

    if (WIDTH < 1 || WIDTH > 31) begin : g_bad_width
        $error("updown_mod_counter: WIDTH must be in 1..31");
    end
    if (MODULO < 2 || longint'(MODULO) > (64'd1 << WIDTH)) begin : g_bad_modulo
        $error("updown_mod_counter: MODULO must be in 2..2**WIDTH");
    end
    if (SATURATE != MODE_WRAP && SATURATE != MODE_SAT) begin : g_bad_sat
        $error("updown_mod_counter: SATURATE must be MODE_WRAP or MODE_SAT");
    end
    if (PRESCALE < 1) begin : g_bad_prescale
        $error("updown_mod_counter: PRESCALE must be >= 1");
    end

    // MODULO-1 always fits in WIDTH bits, so no compare ever needs MODULO itself.
    localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MODULO - 1);
    localparam bit               SAT_EN  = (SATURATE == MODE_SAT);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;
    logic             step;
    logic             restart;

    assign restart = clear | load;

    tick_div #(
        .PRESCALE (PRESCALE)
    ) u_tick_div (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .restart (restart),
        .tick    (step)
    );

    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        ovf_d  = ovf_clr ? 1'b0 : ovf_q;
        if (clear) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = (load_val > CNT_MAX) ? CNT_MAX : load_val;
        end else if (step) begin
            if (up_dn) begin
                if (cnt_q == CNT_MAX) begin
                    cnt_d  = SAT_EN ? cnt_q : '0;
                    wrap_d = 1'b1;
                    ovf_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + WIDTH'(1);
                end
            end else begin
                if (cnt_q == '0) begin
                    cnt_d  = SAT_EN ? cnt_q : CNT_MAX;
                    wrap_d = 1'b1;
                    ovf_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
            ovf_q  <= ovf_d;
        end
    end

    assign cnt  = cnt_q;
    assign wrap = wrap_q;
    assign ovf  = ovf_q;

endmodule : updown_mod_counter

// File: tb/tb_updown_mod_counter.sv
// Four counter variants share one stimulus stream; each is compared every
// cycle against an arithmetic reference model.
//   0: defaults (M16 wrap P1)   1: M10 wrap P1   2: M10 sat P1   3: M10 wrap P3
module tb_updown_mod_counter;

    localparam int N = 4;
    localparam int MODS [N] = '{16, 10, 10, 10};
    localparam int SATS [N] = '{0, 0, 1, 0};
    localparam int PRES [N] = '{1, 1, 1, 3};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       up_dn = 1'b1;
    logic       clear = 1'b0;
    logic       load = 1'b0;
    logic       ovf_clr = 1'b0;
    logic [3:0] load_val = 4'd0;

    logic [3:0] cnt_w  [N];
    logic       wrap_w [N];
    logic       ovf_w  [N];

    always #5 clk = ~clk;

    updown_mod_counter #(.WIDTH(4), .MODULO(16), .SATURATE(0), .PRESCALE(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clear(clear), .load(load),
        .load_val(load_val), .ovf_clr(ovf_clr), .cnt(cnt_w[0]), .wrap(wrap_w[0]), .ovf(ovf_w[0]));
    updown_mod_counter #(.WIDTH(4), .MODULO(10), .SATURATE(0), .PRESCALE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clear(clear), .load(load),
        .load_val(load_val), .ovf_clr(ovf_clr), .cnt(cnt_w[1]), .wrap(wrap_w[1]), .ovf(ovf_w[1]));
    updown_mod_counter #(.WIDTH(4), .MODULO(10), .SATURATE(1), .PRESCALE(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clear(clear), .load(load),
        .load_val(load_val), .ovf_clr(ovf_clr), .cnt(cnt_w[2]), .wrap(wrap_w[2]), .ovf(ovf_w[2]));
    updown_mod_counter #(.WIDTH(4), .MODULO(10), .SATURATE(0), .PRESCALE(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clear(clear), .load(load),
        .load_val(load_val), .ovf_clr(ovf_clr), .cnt(cnt_w[3]), .wrap(wrap_w[3]), .ovf(ovf_w[3]));

    // Reference model: count value, enabled cycles since last restart, flags.
    int m_cnt [N];
    int m_pre [N];
    int m_wrap [N];
    int m_ovf [N];

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_cnt[i] = 0; m_pre[i] = 0; m_wrap[i] = 0; m_ovf[i] = 0;
        end
    endtask

    task automatic model_edge(input int i);
        int nxt;
        bit event_hit;
        event_hit = 0;
        if (clear) begin
            m_cnt[i] = 0;
            m_pre[i] = 0;
        end else if (load) begin
            m_cnt[i] = (int'(load_val) < MODS[i]) ? int'(load_val) : MODS[i] - 1;
            m_pre[i] = 0;
        end else if (en) begin
            m_pre[i] = m_pre[i] + 1;
            if (m_pre[i] == PRES[i]) begin
                m_pre[i] = 0;
                nxt = up_dn ? m_cnt[i] + 1 : m_cnt[i] - 1;
                if (nxt >= MODS[i]) begin
                    event_hit = 1;
                    m_cnt[i] = SATS[i] ? MODS[i] - 1 : nxt - MODS[i];
                end else if (nxt < 0) begin
                    event_hit = 1;
                    m_cnt[i] = SATS[i] ? 0 : nxt + MODS[i];
                end else begin
                    m_cnt[i] = nxt;
                end
            end
        end
        m_wrap[i] = event_hit;
        if (event_hit) m_ovf[i] = 1;
        else if (ovf_clr) m_ovf[i] = 0;
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("%s_cnt%0d", tag, i), int'(cnt_w[i]), m_cnt[i]);
            chk($sformatf("%s_wrap%0d", tag, i), int'(wrap_w[i]), m_wrap[i]);
            chk($sformatf("%s_ovf%0d", tag, i), int'(ovf_w[i]), m_ovf[i]);
        end
    endtask

    // Drive inputs, take one rising edge, advance the model, sample #1 later.
    task automatic cyc(input bit e, input bit u, input bit c, input bit l,
                       input logic [3:0] lv, input bit oc);
        en = e; up_dn = u; clear = c; load = l; load_val = lv; ovf_clr = oc;
        @(posedge clk);
        for (int i = 0; i < N; i++) model_edge(i);
        #1;
        check_all("cyc");
    endtask

    // Reset pulse between clock edges; outputs must drop without an edge.
    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("arst");
        #3;
        rst_n = 1'b1;
    endtask

    initial begin
        bit ud;
        model_reset();
        #3;
        check_all("rst");
        #9;
        rst_n = 1'b1;

        // Defaults counting up from reset: 19 edges -> 3, wrap at 15->0.
        for (int k = 1; k <= 19; k++) begin
            cyc(1, 1, 0, 0, 4'd0, 0);
            if (k == 16) chk("dflt_wrap16", int'(wrap_w[0]), 1);
            if (k == 15) chk("dflt_wrap15", int'(wrap_w[0]), 0);
        end
        chk("dflt_cnt19", int'(cnt_w[0]), 3);
        chk("dflt_ovf", int'(ovf_w[0]), 1);

        // Modulo-10 counting down from 0: 9 with wrap, then 8, 7.
        cyc(1, 1, 1, 0, 4'd0, 0);
        cyc(1, 0, 0, 0, 4'd0, 0);
        chk("m10_dn_cnt", int'(cnt_w[1]), 9);
        chk("m10_dn_wrap", int'(wrap_w[1]), 1);
        cyc(1, 0, 0, 0, 4'd0, 0);
        chk("m10_dn_cnt2", int'(cnt_w[1]), 8);
        cyc(1, 0, 0, 0, 4'd0, 0);

        // Saturating: load 8 then three up steps -> 9,9,9; wrap on 2nd and 3rd.
        cyc(1, 1, 0, 1, 4'd8, 0);
        cyc(1, 1, 0, 0, 4'd0, 0);
        chk("sat_s1_cnt", int'(cnt_w[2]), 9);
        chk("sat_s1_wrap", int'(wrap_w[2]), 0);
        cyc(1, 1, 0, 0, 4'd0, 0);
        chk("sat_s2_cnt", int'(cnt_w[2]), 9);
        chk("sat_s2_wrap", int'(wrap_w[2]), 1);
        cyc(1, 1, 0, 0, 4'd0, 0);
        chk("sat_s3_wrap", int'(wrap_w[2]), 1);

        // Prescale 3 with en 1,1,0,1: one step on the 4th cycle.
        cyc(1, 1, 1, 0, 4'd0, 0);
        cyc(1, 1, 0, 0, 4'd0, 0);
        cyc(1, 1, 0, 0, 4'd0, 0);
        cyc(0, 1, 0, 0, 4'd0, 0);
        chk("pre3_hold", int'(cnt_w[3]), 0);
        cyc(1, 1, 0, 0, 4'd0, 0);
        chk("pre3_step", int'(cnt_w[3]), 1);

        // Load above range clamps to MODULO-1.
        cyc(1, 1, 0, 1, 4'd15, 0);
        chk("clamp_m10", int'(cnt_w[1]), 9);
        chk("clamp_m16", int'(cnt_w[0]), 15);

        // Clear beats load on the same edge.
        cyc(1, 1, 1, 1, 4'd5, 0);
        chk("clr_over_load", int'(cnt_w[0]), 0);

        // ovf_clr alone clears; with a same-edge overflow the set wins.
        cyc(0, 1, 0, 0, 4'd0, 1);
        chk("ovf_cleared", int'(ovf_w[0]), 0);
        cyc(1, 1, 0, 1, 4'd15, 0);
        cyc(1, 1, 0, 0, 4'd0, 1);
        chk("ovf_set_wins", int'(ovf_w[0]), 1);
        chk("ovf_set_wrap", int'(wrap_w[0]), 1);

        // Reset mid-count, no clock edge needed.
        cyc(1, 1, 0, 0, 4'd0, 0);
        async_reset();
        chk("arst_cnt", int'(cnt_w[0]), 0);

        // Randomized traffic.
        ud = 1;
        for (int k = 0; k < 2000; k++) begin
            if ($urandom_range(0, 9) == 0) ud = ~ud;
            cyc($urandom_range(0, 9) < 8, ud,
                $urandom_range(0, 39) == 0,
                $urandom_range(0, 19) == 0,
                4'($urandom_range(0, 15)),
                $urandom_range(0, 9) == 0);
            if ($urandom_range(0, 299) == 0) async_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule : tb_updown_mod_counter

// File: doc/updown_mod_counter.md
UPDOWN_MOD_COUNTER -- requirements
Module: updown_mod_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, which sets the counter width in bits.
REQ-002 The block SHALL have parameter MODULO, default 16, which sets the count range 0..MODULO-1; legal range is 2..2^WIDTH.
REQ-003 The block SHALL have parameter SATURATE, default 0, where 0 means wrap at the range limits and 1 means hold at the range limits.
REQ-004 The block SHALL have parameter PRESCALE, default 1, which sets the number of enabled clock cycles per count step; legal range is 1..65535.
REQ-005 Port clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-006 Port rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-007 Port en  input  1  SHALL be the count enable; when low, the prescaler and counter hold.
REQ-008 Port up_dn  input  1  SHALL be the direction: 1 counts up, 0 counts down.
REQ-009 Port clear  input  1  SHALL be a synchronous clear of the counter and prescaler.
REQ-010 Port load  input  1  SHALL be a synchronous load strobe.
REQ-011 Port load_val  input  WIDTH  SHALL be the value to load.
REQ-012 Port ovf_clr  input  1  SHALL clear the sticky overflow flag.
REQ-013 Port cnt  output  WIDTH  SHALL carry the registered count value.
REQ-014 Port wrap  output  1  SHALL be a registered one-cycle pulse marking a range-limit event.
REQ-015 Port ovf  output  1  SHALL be a registered sticky overflow flag.

Function
REQ-016 Per-edge priority SHALL be: clear, then load, then count step.
REQ-017 Clear: cnt SHALL become 0 and the prescaler SHALL become 0; wrap SHALL be 0 and ovf SHALL be unchanged.
REQ-018 Load: cnt SHALL become min(load_val, MODULO-1) and the prescaler SHALL become 0; no wrap pulse and no ovf set.
REQ-019 Prescaler: the internal step SHALL assert on every PRESCALE-th cycle with en=1, counted from reset, clear or load; PRESCALE=1 SHALL give a step on every en cycle.
REQ-020 On a step, cnt SHALL update at that same rising edge, with no extra latency.
REQ-021 On an up step at cnt=MODULO-1: cnt SHALL become 0 if SATURATE=0 and SHALL hold if SATURATE=1; in both cases wrap=1 for one cycle and ovf is set.
REQ-022 On a down step at cnt=0: cnt SHALL become MODULO-1 if SATURATE=0 and SHALL hold if SATURATE=1; in both cases wrap=1 and ovf is set.
REQ-023 wrap SHALL be 0 on every other cycle; in saturate mode, repeated steps at the limit SHALL pulse wrap on each step.
REQ-024 A direction change SHALL take effect on the next step and SHALL NOT reset the prescaler.
REQ-025 When ovf_clr and an overflow event occur on the same edge, set SHALL win and ovf stays 1.
REQ-026 With en=0, the count, the prescaler and wrap (=0) SHALL hold; clear and load SHALL still act.
REQ-027 All arithmetic SHALL be performed within WIDTH bits, with no intermediate overflow for MODULO=2^WIDTH.

Reset
REQ-028 rst_n=0 SHALL immediately force cnt=0, wrap=0, ovf=0 and prescaler=0, independent of clk.
REQ-029 Reset deassertion SHALL be accepted synchronously; the first step occurs PRESCALE enabled cycles after release.
REQ-030 Reset asserted mid-count SHALL abort any pending step, with no wrap pulse emitted.

Structure
REQ-031 The shared package updown_counter_pkg SHALL hold the SATURATE mode constants (MODE_WRAP=0, MODE_SAT=1) and the prescaler counter width constant (16).
REQ-032 The prescaler SHALL be a separate sub-module tick_div (inputs clk, rst_n, en, restart; output tick), instantiated once.
REQ-033 The implementation SHALL contain parameter legality checks, including MODULO<=2^WIDTH and PRESCALE>=1, as elaboration-time assertions.

Verification
REQ-034 Defaults, en=1, up_dn=1, 20 cycles after reset -> cnt 0..15,0..3; wrap high exactly on the cycle cnt shows 0 after 15; ovf=1.
REQ-035 WIDTH=4, MODULO=10, up_dn=0, starting from 0 -> cnt 9,8,...; wrap pulses when 0->9.
REQ-036 SATURATE=1, MODULO=10, load_val=8, then 3 up steps -> cnt 9,9,9; wrap pulses on the 2nd and 3rd steps.
REQ-037 PRESCALE=3, en toggled as 1,1,0,1 -> a single step on the 4th cycle; load_val=15 with MODULO=10 -> cnt=9.
REQ-038 clear and load on the same edge -> cnt=0; ovf_clr during an overflow event -> ovf stays 1; rst_n pulsed low mid-count -> cnt=0 without waiting for a clk edge.
